// File: rtl/eros_apb_obi_bridge.sv
// rtl/eros_apb_obi_bridge.sv - blocking APB4 completer to OBI manager bridge, one transfer in flight
// Optional address range check (error response without OBI access): define EROS_APB_OBI_ADDR_CHECK_EN.
package eros_pkg;
  localparam logic [31:0] GLOBAL_BASE_ADDRESS = 32'h0000_0000;
  localparam logic [31:0] GLOBAL_END_ADDRESS  = 32'h0010_0000;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_rsp_t;
endpackage

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module eros_apb_obi_bridge #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = eros_pkg::GLOBAL_BASE_ADDRESS,
  parameter logic [ADDR_WIDTH-1:0] ADDR_END   = eros_pkg::GLOBAL_END_ADDRESS,
  parameter type                   apb_req_t  = eros_pkg::apb_req_t,
  parameter type                   apb_rsp_t  = eros_pkg::apb_rsp_t,
  parameter type                   obi_req_t  = obi_pkg::obi_req_t,
  parameter type                   obi_rsp_t  = obi_pkg::obi_resp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  apb_req_t apb_req_i,
  output apb_rsp_t apb_rsp_o,
  output obi_req_t obi_req_o,
  input  obi_rsp_t obi_rsp_i,
  output logic     busy_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [STRB_WIDTH-1:0]   be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    pready_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic                    err_q;
  logic                    start;
  logic                    addr_bad;
  logic                    unused;

  assign start  = apb_req_i.psel & apb_req_i.penable;
  assign unused = ^{apb_req_i.pprot, ADDR_BASE, ADDR_END};

`ifdef EROS_APB_OBI_ADDR_CHECK_EN
  // Offset compare folds both bounds into one unsigned test; below-base wraps high.
  assign addr_bad = (apb_req_i.paddr - ADDR_BASE) >= (ADDR_END - ADDR_BASE);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = addr_bad ? RESP : REQ;
      REQ:     if (obi_rsp_i.gnt) state_d = WAIT;
      WAIT:    if (obi_rsp_i.rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        addr_q  <= apb_req_i.paddr;
        we_q    <= apb_req_i.pwrite;
        be_q    <= apb_req_i.pwrite ? apb_req_i.pstrb : '1;
        wdata_q <= apb_req_i.pwdata;
      end
      pready_q <= (state_d == RESP);
      prdata_q <= (state_q == WAIT && obi_rsp_i.rvalid && !we_q) ? obi_rsp_i.rdata : '0;
      err_q    <= (state_q == IDLE) && start && addr_bad;
    end
  end

  always_comb begin
    obi_req_o       = '0;
    obi_req_o.req   = (state_q == REQ);
    obi_req_o.we    = we_q;
    obi_req_o.be    = be_q;
    obi_req_o.addr  = addr_q;
    obi_req_o.wdata = wdata_q;
  end

  always_comb begin
    apb_rsp_o         = '0;
    apb_rsp_o.pready  = pready_q;
    apb_rsp_o.prdata  = prdata_q;
    apb_rsp_o.pslverr = err_q;
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_eros_apb_obi_bridge.sv
// tb/tb_eros_apb_obi_bridge.sv - self-checking bench for eros_apb_obi_bridge
// Covers EROS_APB_OBI_ADDR_CHECK_EN vectors when that macro is defined.
module tb_eros_apb_obi_bridge;

  logic                clk = 1'b0;
  logic                rst_ni;
  eros_pkg::apb_req_t  apb_req;
  eros_pkg::apb_rsp_t  apb_rsp;
  obi_pkg::obi_req_t   obi_req;
  obi_pkg::obi_resp_t  obi_rsp;
  logic                busy;

  always #5 clk = ~clk;

  eros_apb_obi_bridge dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .apb_req_i (apb_req),
    .apb_rsp_o (apb_rsp),
    .obi_req_o (obi_req),
    .obi_rsp_i (obi_rsp),
    .busy_o    (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          gnt_stall;
    int          rv_stall;
    logic [31:0] rdata;
    logic        drop;
    logic [3:0]  exp_be;
    logic [31:0] exp_prdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   n, gcnt, rcnt, phase, reqs;
    bit   done;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_req", obi_req.req, 0);
    apb_req.psel    = 1'b1;
    apb_req.penable = 1'b0;
    apb_req.paddr   = v.addr;
    apb_req.pwrite  = v.we;
    apb_req.pwdata  = v.wdata;
    apb_req.pstrb   = v.strb;
    apb_req.pprot   = 3'b010;
    e.prdata = v.exp_prdata;
    e.err    = v.exp_err;
    e.lat    = v.exp_lat;
    sb.push_back(e);
    @(negedge clk);
    apb_req.penable = 1'b1;
    n = 0; gcnt = 0; rcnt = 0; phase = 0; reqs = 0; done = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      obi_rsp = '0;
      if (v.drop && n == 1) begin
        apb_req.psel    = 1'b0;
        apb_req.penable = 1'b0;
        apb_req.paddr   = 32'hFFFF_FFFC;
        apb_req.pwdata  = 32'h5555_AAAA;
        apb_req.pwrite  = ~v.we;
      end
      if (apb_rsp.pready) begin
        check("busy_resp", busy, 1);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: pready with no expected entry");
        end else begin
          e = sb.pop_front();
          check("prdata", apb_rsp.prdata, e.prdata);
          check("pslverr", apb_rsp.pslverr, e.err);
          check("latency", n, e.lat);
        end
        apb_req.psel    = 1'b0;
        apb_req.penable = 1'b0;
        done = 1;
      end else begin
        check("busy", busy, 1);
        check("prdata_idle", apb_rsp.prdata, 0);
        if (obi_req.req) begin
          reqs++;
          check("obi_addr", obi_req.addr, v.addr);
          check("obi_we", obi_req.we, v.we);
          check("obi_be", obi_req.be, v.exp_be);
          check("obi_wdata", obi_req.wdata, v.wdata);
          if (gcnt == v.gnt_stall) begin
            obi_rsp.gnt = 1'b1;
            phase = 1;
          end else gcnt++;
        end else if (phase == 1) begin
          if (rcnt == v.rv_stall) begin
            obi_rsp.rvalid = 1'b1;
            obi_rsp.rdata  = v.rdata;
            phase = 2;
          end else rcnt++;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: no pready within %0d cycles (got none, required one)", n);
    end
    check("req_cycles", reqs, v.exp_err ? 0 : v.gnt_stall + 1);
  endtask

  initial begin
    // we addr wdata strb gstall rstall rdata drop exp_be exp_prdata err lat
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 3, 0, 32'h0, 1'b0, 4'b0011, 32'h0, 1'b0, 6});
    vecs.push_back('{1'b0, 32'h0000_0044, 32'h0, 4'h3, 1, 2, 32'hA5A5_0F0F, 1'b0, 4'hF, 32'hA5A5_0F0F, 1'b0, 6});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h8765_4321, 4'b1000, 0, 1, 32'hCAFE_F00D, 1'b0, 4'b1000, 32'h0, 1'b0, 4});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h0000_0030, 32'h0, 4'h0, 2, 0, 32'h0BAD_F00D, 1'b1, 4'hF, 32'h0BAD_F00D, 1'b0, 5});
`ifdef EROS_APB_OBI_ADDR_CHECK_EN
    vecs.push_back('{1'b0, eros_pkg::GLOBAL_END_ADDRESS, 32'h0, 4'h0, 0, 0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 1});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, 32'h1357_9BDF, 1'b0, 4'hF, 32'h1357_9BDF, 1'b0, 3});
`endif

    apb_req = '0;
    obi_rsp = '0;
    rst_ni  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", obi_req.req, 0);
    check("rst_pready", apb_rsp.pready, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("reset_obi_all", obi_req, 0);
    check("reset_apb_prdata", apb_rsp.prdata, 0);
    check("reset_apb_flags", {apb_rsp.pready, apb_rsp.pslverr}, 0);
    check("reset_busy", busy, 0);

    // Orphan gnt/rvalid in IDLE must be ignored.
    for (int i = 0; i < 3; i++) begin
      obi_rsp.gnt    = 1'b1;
      obi_rsp.rvalid = 1'b1;
      obi_rsp.rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("orphan_busy", busy, 0);
      check("orphan_pready", apb_rsp.pready, 0);
      check("orphan_prdata", apb_rsp.prdata, 0);
    end
    obi_rsp = '0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while in WAIT, then a stale rvalid.
    @(negedge clk);
    apb_req.psel    = 1'b1;
    apb_req.penable = 1'b0;
    apb_req.paddr   = 32'h0000_0050;
    apb_req.pwrite  = 1'b0;
    @(negedge clk);
    apb_req.penable = 1'b1;
    @(negedge clk);
    check("rstw_req", obi_req.req, 1);
    obi_rsp.gnt = 1'b1;
    @(negedge clk);
    obi_rsp = '0;
    check("rstw_busy_wait", busy, 1);
    check("rstw_req_wait", obi_req.req, 0);
    rst_ni = 1'b0;
    apb_req.psel    = 1'b0;
    apb_req.penable = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_obi", obi_req, 0);
    check("rstw_pready", apb_rsp.pready, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    obi_rsp.rvalid = 1'b1;
    obi_rsp.rdata  = 32'h7777_7777;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obi_rsp = '0;
      check("rstw_after_busy", busy, 0);
      check("rstw_after_pready", apb_rsp.pready, 0);
      check("rstw_after_req", obi_req.req, 0);
    end

    run_txn(vecs[0]);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
